// File: rtl/pancham_pkg.sv
// rtl/pancham_pkg.sv - shared widths, state encoding and helpers for the pancham arbiter
package pancham_pkg;

  localparam int MSG_W   = 128;
  localparam int WIDTH_W = 8;
  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // The core only accepts 1..128 message bits; anything else is rejected without issuing.
  function automatic logic width_illegal(input logic [WIDTH_W-1:0] w);
    return (w == '0) || (w > WIDTH_W'(MSG_W));
  endfunction

endpackage

// File: rtl/pancham_arbiter_if.sv
// rtl/pancham_arbiter_if.sv - requester and core-side signal bundle for the pancham arbiter
interface pancham_arbiter_if
  import pancham_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*MSG_W-1:0]   req_msg;
  logic [NREQ*WIDTH_W-1:0] req_width;
  logic [NREQ-1:0]         req_ack;

  logic                    resp_valid;
  logic [IDX_W-1:0]        resp_id;
  logic [MSG_W-1:0]        resp_digest;
  logic                    resp_err;

  logic [MSG_W-1:0]        core_msg_in;
  logic [WIDTH_W-1:0]      core_msg_in_width;
  logic                    core_msg_in_valid;
  logic [MSG_W-1:0]        core_msg_output;
  logic                    core_msg_out_valid;
  logic                    core_ready;

  // Arbiter side.
  modport slave (
    input  req_valid, req_msg, req_width,
    input  core_msg_output, core_msg_out_valid, core_ready,
    output req_ack, resp_valid, resp_id, resp_digest, resp_err,
    output core_msg_in, core_msg_in_width, core_msg_in_valid
  );

  // Requesters plus core side.
  modport master (
    output req_valid, req_msg, req_width,
    output core_msg_output, core_msg_out_valid, core_ready,
    input  req_ack, resp_valid, resp_id, resp_digest, resp_err,
    input  core_msg_in, core_msg_in_width, core_msg_in_valid
  );

endinterface

// File: rtl/pancham_rr_pick.sv
// rtl/pancham_rr_pick.sv - combinational round-robin selector starting after the last grant
module pancham_rr_pick
  import pancham_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             any_valid
);

  int              idx;
  logic [NREQ-1:0] shifted;

  // Scan upward from last_grant+1, wrapping at NREQ; the first valid requester wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    shifted   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx     = (int'(last_grant) + k) % NREQ;
      shifted = valid >> idx;
      if (!any_valid && shifted[0]) begin
        grant     = IDX_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pancham_arbiter.sv
// rtl/pancham_arbiter.sv - round-robin front end sharing one pancham MD5 core among NREQ requesters
module pancham_arbiter
  import pancham_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input logic              clk,
  input logic              reset,
  pancham_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [MSG_W-1:0]   digest_q, digest_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   grant;
  logic               any_valid;
  logic               grant_now;
  logic [NREQ-1:0]    ack_vec;

  // Padded to a power of two so the grant index addresses them exactly.
  logic [MSG_W-1:0]   msg_arr   [MAX_REQ];
  logic [WIDTH_W-1:0] width_arr [MAX_REQ];

  for (genvar i = 0; i < MAX_REQ; i++) begin : g_slice
    if (i < NREQ) begin : g_live
      assign msg_arr[i]   = bus.req_msg[i*MSG_W +: MSG_W];
      assign width_arr[i] = bus.req_width[i*WIDTH_W +: WIDTH_W];
    end else begin : g_pad
      assign msg_arr[i]   = '0;
      assign width_arr[i] = '0;
    end
  end

  pancham_rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .valid     (bus.req_valid),
    .last_grant(last_grant_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign grant_now = (state_q == ST_IDLE) && bus.core_ready && any_valid;

  // Transaction sequencing: capture in IDLE, one-cycle issue, bounded wait, one-cycle response.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    msg_d        = msg_q;
    width_d      = width_q;
    digest_d     = digest_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_now) begin
          id_d    = grant;
          msg_d   = msg_arr[grant];
          width_d = width_arr[grant];
          if (width_illegal(width_arr[grant])) begin
            // Rejected up front: the core never sees this message.
            err_d    = 1'b1;
            digest_d = '0;
            state_d  = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A digest arriving on the final wait cycle still beats the timeout.
        if (bus.core_msg_out_valid) begin
          digest_d = bus.core_msg_output;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          digest_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_grant_d = id_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last_grant resets to the top index so requester 0 is first in line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      id_q         <= '0;
      msg_q        <= '0;
      width_q      <= '0;
      digest_q     <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      msg_q        <= msg_d;
      width_q      <= width_d;
      digest_q     <= digest_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Ack is decoded in the grant cycle and forced low while reset is held.
  assign ack_vec     = grant_now ? (NREQ'(1) << grant) : '0;
  assign bus.req_ack = reset ? ack_vec : '0;

  assign bus.core_msg_in_valid = (state_q == ST_ISSUE);
  assign bus.core_msg_in       = (state_q == ST_ISSUE) ? msg_q   : '0;
  assign bus.core_msg_in_width = (state_q == ST_ISSUE) ? width_q : '0;

  assign bus.resp_valid  = (state_q == ST_RESP);
  assign bus.resp_id     = (state_q == ST_RESP) ? id_q     : '0;
  assign bus.resp_digest = (state_q == ST_RESP) ? digest_q : '0;
  assign bus.resp_err    = (state_q == ST_RESP) ? err_q    : 1'b0;

endmodule
